// File: rtl/sprite_hit_pipe.sv
// sprite_hit_pipe: per-pixel sprite hit test with vsync-latched shadow registers.
// Latches object state once per frame, then runs a 2-stage hit test and priority
// encode (lowest slot index wins).
// Optional macro SPRITE_HIT_COLLIDE_EN adds sticky collide/shot overlap flags.

// Per-slot bounding-box test (combinational).
module sprite_hit_lane #(
  parameter int COORD_W  = 10,
  parameter int OBJ_SIZE = 32
) (
  input  logic               i_en,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_sx,
  input  logic [COORD_W-1:0] i_sy,
  output logic               o_in,
  output logic [5:0]         o_dx,
  output logic [5:0]         o_dy
);
  localparam logic [COORD_W:0] LP_SIZE = (COORD_W+1)'(OBJ_SIZE);

  logic [COORD_W:0] w_dx, w_dy;

  // Extra MSB makes pixels left of / above the sprite show up as negative,
  // so a sprite near the right edge never wraps around to x=0.
  assign w_dx = {1'b0, i_x} - {1'b0, i_sx};
  assign w_dy = {1'b0, i_y} - {1'b0, i_sy};
  assign o_in = i_en & ~w_dx[COORD_W] & (w_dx < LP_SIZE)
                     & ~w_dy[COORD_W] & (w_dy < LP_SIZE);
  assign o_dx = w_dx[5:0];
  assign o_dy = w_dy[5:0];
endmodule

module sprite_hit_pipe #(
  parameter int N_OBJ    = 10,
  parameter int OBJ_SIZE = 32,
  parameter int COORD_W  = 10
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic                     vsync,
  input  logic                     pix_valid,
  input  logic [COORD_W-1:0]       draw_x,
  input  logic [COORD_W-1:0]       draw_y,
  input  logic [N_OBJ-1:0]         obj_en,
  input  logic [N_OBJ*COORD_W-1:0] obj_x,
  input  logic [N_OBJ*COORD_W-1:0] obj_y,
  output logic                     hit_valid,
  output logic                     hit,
  output logic [3:0]               hit_id,
  output logic [5:0]               off_x,
  output logic [5:0]               off_y,
  output logic                     frame_latched
`ifdef SPRITE_HIT_COLLIDE_EN
  ,
  output logic [2:0]               collide,
  output logic [8:0]               shot
`endif
);
  typedef enum logic {RUN, PEND} state_t;

  state_t                          r_state, w_state_nxt;
  logic                            r_vs_prev, w_vs_fall, w_latch;
  logic [N_OBJ-1:0]                r_sen;
  logic [N_OBJ-1:0][COORD_W-1:0]   r_sx, r_sy, w_ox, w_oy;
  logic [N_OBJ-1:0]                w_in, r_s1_in;
  logic [N_OBJ-1:0][5:0]           w_dx, w_dy, r_s1_dx, r_s1_dy;
  logic                            r_s1_vld;
  logic                            w_hit;
  logic [3:0]                      w_id;
  logic [5:0]                      w_wdx, w_wdy;

  // Packed array layout matches the flat PIO bus slot ordering.
  assign w_ox      = obj_x;
  assign w_oy      = obj_y;
  assign w_vs_fall = r_vs_prev & ~vsync;

  // Frame latch FSM: state register and vsync history.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state   <= RUN;
      r_vs_prev <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_vs_prev <= vsync;
    end
  end

  // Next state: arm on vsync fall, latch on first blank pixel; extra edges in PEND are absorbed.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      RUN:  if (w_vs_fall) w_state_nxt = PEND;
      PEND: if (!pix_valid) begin
        w_latch     = 1'b1;
        w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Shadow object set, updated only outside the visible region.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sen         <= '0;
      r_sx          <= '0;
      r_sy          <= '0;
      frame_latched <= 1'b0;
    end else begin
      frame_latched <= w_latch;
      if (w_latch) begin
        r_sen <= obj_en;
        r_sx  <= w_ox;
        r_sy  <= w_oy;
      end
    end
  end

  for (genvar g = 0; g < N_OBJ; g++) begin : g_lane
    sprite_hit_lane #(.COORD_W(COORD_W), .OBJ_SIZE(OBJ_SIZE)) u_lane (
      .i_en (r_sen[g]),
      .i_x  (draw_x),
      .i_y  (draw_y),
      .i_sx (r_sx[g]),
      .i_sy (r_sy[g]),
      .o_in (w_in[g]),
      .o_dx (w_dx[g]),
      .o_dy (w_dy[g])
    );
  end

  // Stage 1: register per-slot hit bits and offsets.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_s1_in  <= '0;
      r_s1_dx  <= '0;
      r_s1_dy  <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_in  <= w_in;
      r_s1_dx  <= w_dx;
      r_s1_dy  <= w_dy;
      r_s1_vld <= pix_valid;
    end
  end

  // Priority encode: scan downward so the lowest set index is the final winner.
  always_comb begin
    w_hit = |r_s1_in;
    w_id  = '0;
    w_wdx = '0;
    w_wdy = '0;
    for (int i = N_OBJ-1; i >= 0; i--) begin
      if (r_s1_in[i]) begin
        w_id  = 4'(i);
        w_wdx = r_s1_dx[i];
        w_wdy = r_s1_dy[i];
      end
    end
  end

  // Stage 2: registered outputs, zeroed on blank pixels.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hit_valid <= 1'b0;
      hit       <= 1'b0;
      hit_id    <= '0;
      off_x     <= '0;
      off_y     <= '0;
    end else begin
      hit_valid <= r_s1_vld;
      hit       <= r_s1_vld & w_hit;
      hit_id    <= r_s1_vld ? w_id  : 4'd0;
      off_x     <= r_s1_vld ? w_wdx : 6'd0;
      off_y     <= r_s1_vld ? w_wdy : 6'd0;
    end
  end

`ifdef SPRITE_HIT_COLLIDE_EN
  logic [2:0] w_col_set;
  logic [8:0] w_shot_set;

  // Overlap detect on the staged pixel: samus is slot 6, bullets 3-5, monsters 7-9.
  always_comb begin
    w_col_set  = '0;
    w_shot_set = '0;
    for (int m = 0; m < 3; m++) begin
      w_col_set[m] = r_s1_vld & r_s1_in[6] & r_s1_in[7+m];
      for (int b = 0; b < 3; b++)
        w_shot_set[3*b+m] = r_s1_vld & r_s1_in[3+b] & r_s1_in[7+m];
    end
  end

  // Sticky flags cleared per frame; a coincident set wins over the clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      collide <= '0;
      shot    <= '0;
    end else begin
      collide <= (w_latch ? 3'd0 : collide) | w_col_set;
      shot    <= (w_latch ? 9'd0 : shot)    | w_shot_set;
    end
  end
`endif
endmodule

// File: tb/tb_sprite_hit_pipe.sv
// Scoreboard bench for sprite_hit_pipe: the driver pushes expected results,
// and a negedge monitor pops and compares whenever hit_valid is high.
module tb_sprite_hit_pipe;
  localparam int N = 10;
  localparam int W = 10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           vsync, pix_valid;
  logic [W-1:0]   draw_x, draw_y;
  logic [N-1:0]   obj_en;
  logic [N*W-1:0] obj_x, obj_y;
  logic           hit_valid, hit, frame_latched;
  logic [3:0]     hit_id;
  logic [5:0]     off_x, off_y;
`ifdef SPRITE_HIT_COLLIDE_EN
  logic [2:0]     collide;
  logic [8:0]     shot;
`endif

  sprite_hit_pipe dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .vsync(vsync), .pix_valid(pix_valid),
    .draw_x(draw_x), .draw_y(draw_y), .obj_en(obj_en), .obj_x(obj_x), .obj_y(obj_y),
    .hit_valid(hit_valid), .hit(hit), .hit_id(hit_id), .off_x(off_x), .off_y(off_y),
    .frame_latched(frame_latched)
`ifdef SPRITE_HIT_COLLIDE_EN
    , .collide(collide), .shot(shot)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       h;
    logic [3:0] id;
    logic [5:0] ox, oy;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: compare each valid output against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && hit_valid) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_empty: unexpected output hit=%0d id=%0d", hit, hit_id);
      end else begin
        e = q.pop_front();
        if (hit !== e.h || hit_id !== e.id || off_x !== e.ox || off_y !== e.oy ||
            cyc != e.cyc + 2) begin
          fails++;
          $display("FAIL sb_pix: got hit=%0d id=%0d ox=%0d oy=%0d cyc=%0d expected hit=%0d id=%0d ox=%0d oy=%0d cyc=%0d",
                   hit, hit_id, off_x, off_y, cyc, e.h, e.id, e.ox, e.oy, e.cyc + 2);
        end
      end
    end else if (rst_n) begin
      tests++;
      if ({hit, hit_id, off_x, off_y} != 17'd0) begin
        fails++;
        $display("FAIL idle_zero: got hit=%0d id=%0d ox=%0d oy=%0d expected all 0",
                 hit, hit_id, off_x, off_y);
      end
    end
  end

  task automatic pix(input int x, input int y, input logic v,
                     input logic h, input int id, input int ox, input int oy);
    exp_t e;
    @(posedge clk); #1;
    draw_x = W'(x); draw_y = W'(y); pix_valid = v;
    if (v) begin
      e.h = h; e.id = 4'(id); e.ox = 6'(ox); e.oy = 6'(oy); e.cyc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; pix_valid = 1'b0;
    end
  endtask

  task automatic set_obj(input int s, input int x, input int y);
    obj_x[s*W +: W] = W'(x);
    obj_y[s*W +: W] = W'(y);
  endtask

  // Bounded wait for the latch pulse, then confirm it lasts one cycle.
  task automatic wait_latch(input string nm);
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!frame_latched && n < 10);
    chk({nm, "_seen"}, int'(frame_latched), 1);
    @(negedge clk);
    chk({nm, "_pulse"}, int'(frame_latched), 0);
  endtask

  task automatic latch_frame(input string nm);
    @(posedge clk); #1;
    pix_valid = 1'b0; vsync = 1'b0;
    wait_latch(nm);
    vsync = 1'b1;
    idle(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; vsync = 1'b1; pix_valid = 1'b0;
    draw_x = '0; draw_y = '0; obj_en = '0; obj_x = '0; obj_y = '0;
    #12;
    chk("rst_hit_valid", int'(hit_valid), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_hit_id", int'(hit_id), 0);
    chk("rst_off", int'({off_x, off_y}), 0);
    chk("rst_latched", int'(frame_latched), 0);
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    // Samus alone.
    obj_en = 10'b00_0100_0000; set_obj(6, 100, 200);
    latch_frame("latch1");
    pix(110, 210, 1, 1, 6, 10, 10);
    pix( 99, 210, 1, 0, 0, 0, 0);
    pix(131, 231, 1, 1, 6, 31, 31);
    pix(132, 200, 1, 0, 0, 0, 0);
    idle(3);

    // Bullet1 on top of samus wins on priority.
    obj_en[3] = 1'b1; set_obj(3, 100, 200);
    latch_frame("latch2");
    pix(101, 201, 1, 1, 3, 1, 1);
    pix(120, 230, 1, 1, 3, 20, 30);
    idle(3);

    // Mid-frame move: no effect until the deferred latch; extra vsync edge absorbed.
    set_obj(3, 500, 200);
    for (int i = 0; i < 5; i++) begin
      vsync = (i == 2);
      pix(101, 201, 1, 1, 3, 1, 1);
      chk("defer_no_latch", int'(frame_latched), 0);
    end
    vsync = 1'b0;
    @(posedge clk); #1; pix_valid = 1'b0;
    wait_latch("latch3");
    chk("latch3_single", int'(frame_latched), 0);
    vsync = 1'b1;
    pix(101, 201, 1, 1, 6, 1, 1);
    pix(510, 205, 1, 1, 3, 10, 5);
    idle(3);

    // Monster1 at the right edge: no wrap.
    obj_en = 10'b00_1000_0000; set_obj(7, 1010, 0);
    latch_frame("latch4");
    pix(1023,  5, 1, 1, 7, 13, 5);
    pix(1009,  5, 1, 0, 0, 0, 0);
    pix(   5,  5, 1, 0, 0, 0, 0);
    pix(1015, 31, 1, 1, 7, 5, 31);
    pix(1015, 32, 1, 0, 0, 0, 0);
    idle(3);

    // Valid pattern 1,0,1,1.
    pix(1020, 0, 1, 1, 7, 10, 0);
    pix(1020, 0, 0, 0, 0, 0, 0);
    pix(1011, 1, 1, 1, 7, 1, 1);
    pix(1023, 2, 1, 1, 7, 13, 2);
    idle(4);

    // Reset mid-stream clears outputs immediately and drops the shadow set.
    pix(1020, 0, 1, 1, 7, 10, 0);
    pix(1011, 1, 1, 1, 7, 1, 1);
    @(posedge clk); #1;
    chk("pre_reset_hit", int'(hit), 1);
    chk("pre_reset_id", int'(hit_id), 7);
    #1; rst_n = 1'b0; pix_valid = 1'b0;
    #1;
    chk("mid_rst_valid", int'(hit_valid), 0);
    chk("mid_rst_hit", int'(hit), 0);
    chk("mid_rst_id", int'(hit_id), 0);
    chk("mid_rst_off", int'({off_x, off_y}), 0);
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    idle(1);
    pix(1023, 5, 1, 0, 0, 0, 0);
    idle(3);

`ifdef SPRITE_HIT_COLLIDE_EN
    // Bullet2 and monster3 share a single pixel.
    obj_en = 10'b10_0001_0000; set_obj(4, 300, 300); set_obj(9, 331, 331);
    latch_frame("latch5");
    chk("shot_clear", int'(shot), 0);
    pix(331, 331, 1, 1, 4, 31, 31);
    idle(4);
    chk("shot5_set", int'(shot), 9'h020);
    chk("collide_none", int'(collide), 0);
    latch_frame("latch6");
    chk("shot_cleared", int'(shot), 0);
`endif

    idle(4);
    chk("sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
